pipe_out_check_gen: RTL

Parametrised pipe-out data source for host Pipe Out throughput and integrity testing. It produces a selectable deterministic data pattern on each read. It models a virtual FIFO whose fill rate is set by a circular throttle register, and drives a block-ready flag from that level. Beyond the fixed 32-bit generation, it adds configurable data, level and throttle widths, a configurable ready threshold, a pattern restart, sticky underflow and overflow flags, and a read-word counter.

---
 rtl/pipe_check_pkg.sv | 19 +
 rtl/pattern_gen_w.sv | 42 ++++
 rtl/pipe_out_check_gen.sv | 89 ++++++++
 3 files changed

// File: rtl/pipe_check_pkg.sv
// pipe_check_pkg: pattern mode encodings and the xorshift step shared by the
// pipe-out checker.
package pipe_check_pkg;
    localparam logic [2:0] PAT_FIXED = 3'd0;
    localparam logic [2:0] PAT_COUNT = 3'd1;
    localparam logic [2:0] PAT_WALK1 = 3'd2;
    localparam logic [2:0] PAT_WALK0 = 3'd3;
    localparam logic [2:0] PAT_LFSR  = 3'd4;
    localparam int XS_A = 13;
    localparam int XS_B = 7;
    localparam int XS_C = 17;

    function automatic logic [63:0] xorshift64(input logic [63:0] s);
        logic [63:0] t;
        t = s ^ (s << XS_A);
        t = t ^ (t >> XS_B);
        return t ^ (t << XS_C);
    endfunction
endpackage

// File: rtl/pattern_gen_w.sv
// pattern_gen_w: runs every pattern state in parallel and muxes the selected
// one out; states advance only when a word is consumed.
module pattern_gen_w
    import pipe_check_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter logic [63:0] LFSR_SEED  = 64'h0123_4567_89AB_CDEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  restart,
    input  logic [2:0]            mode,
    input  logic [DATA_WIDTH-1:0] fixed_i,
    output logic [DATA_WIDTH-1:0] data_o
);
    logic [DATA_WIDTH-1:0] cnt_q, cnt_d, walk_q, walk_d;
    logic [63:0]           lfsr_q, lfsr_d;
    logic                  init;

    assign init = reset || restart;

    // restart wins over a simultaneous advance
    always_comb begin
        cnt_d  = init ? '0 : enable ? cnt_q + DATA_WIDTH'(1) : cnt_q;
        walk_d = init ? DATA_WIDTH'(1)
               : enable ? {walk_q[DATA_WIDTH-2:0], walk_q[DATA_WIDTH-1]} : walk_q;
        lfsr_d = init ? LFSR_SEED : enable ? xorshift64(lfsr_q) : lfsr_q;
        data_o = mode == PAT_FIXED ? fixed_i
               : mode == PAT_COUNT ? cnt_q
               : mode == PAT_WALK1 ? walk_q
               : mode == PAT_WALK0 ? ~walk_q
               : mode == PAT_LFSR  ? lfsr_q[DATA_WIDTH-1:0]
               : '0;
    end

    always_ff @(posedge clk) begin
        cnt_q  <= cnt_d;
        walk_q <= walk_d;
        lfsr_q <= lfsr_d;
    end
endmodule

// File: rtl/pipe_out_check_gen.sv
// pipe_out_check_gen: pipe-out data source with a throttled virtual FIFO level,
// block-ready flag, sticky under/overflow and a read-word counter.
module pipe_out_check_gen
    import pipe_check_pkg::*;
#(
    parameter int          DATA_WIDTH     = 32,
    parameter int          LEVEL_WIDTH    = 16,
    parameter int          READY_THRESH   = 1024,
    parameter int          THROTTLE_WIDTH = 32,
    parameter logic [63:0] LFSR_SEED      = 64'h0123_4567_89AB_CDEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pipe_out_read,
    output logic [DATA_WIDTH-1:0]     pipe_out_data,
    output logic                      pipe_out_ready,
    input  logic                      throttle_set,
    input  logic [THROTTLE_WIDTH-1:0] throttle_val,
    input  logic [DATA_WIDTH-1:0]     fixed_pattern,
    input  logic [2:0]                pattern,
    input  logic                      pattern_restart,
    output logic                      underflow,
    output logic                      overflow,
    output logic [31:0]               word_count,
    output logic [LEVEL_WIDTH-1:0]    level
);
    localparam logic [LEVEL_WIDTH-1:0] LVL_MAX = '1;
    localparam logic [LEVEL_WIDTH-1:0] THRESH  = LEVEL_WIDTH'(READY_THRESH);

    logic [DATA_WIDTH-1:0]     gen_data, data_q, data_d;
    logic [LEVEL_WIDTH-1:0]    level_q, level_d;
    logic [THROTTLE_WIDTH-1:0] thr_q, thr_d;
    logic [31:0]               count_q, count_d;
    logic                      ready_q, ready_d, under_q, under_d, over_q, over_d;
    logic                      wr, full, empty;

    pattern_gen_w #(.DATA_WIDTH(DATA_WIDTH), .LFSR_SEED(LFSR_SEED)) u_gen (
        .clk     (clk),
        .reset   (reset),
        .enable  (pipe_out_read),
        .restart (pattern_restart),
        .mode    (pattern),
        .fixed_i (fixed_pattern),
        .data_o  (gen_data)
    );

    // a simultaneous read and write cancel, so neither flag can set then
    always_comb begin
        wr      = thr_q[0];
        full    = level_q == LVL_MAX;
        empty   = level_q == '0;
        level_d = (pipe_out_read == wr) ? level_q
                : wr ? (full ? level_q : level_q + LEVEL_WIDTH'(1))
                : (empty ? level_q : level_q - LEVEL_WIDTH'(1));
        over_d  = over_q | (wr & ~pipe_out_read & full);
        under_d = under_q | (pipe_out_read & ~wr & empty);
        ready_d = level_q >= THRESH;
        data_d  = pipe_out_read ? gen_data : data_q;
        count_d = count_q + 32'(pipe_out_read);
        thr_d   = throttle_set ? throttle_val : {thr_q[0], thr_q[THROTTLE_WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            ready_q <= 1'b0;
            under_q <= 1'b0;
            over_q  <= 1'b0;
            count_q <= '0;
            level_q <= '0;
            thr_q   <= throttle_val;
        end else begin
            data_q  <= data_d;
            ready_q <= ready_d;
            under_q <= under_d;
            over_q  <= over_d;
            count_q <= count_d;
            level_q <= level_d;
            thr_q   <= thr_d;
        end
    end

    assign pipe_out_data  = data_q;
    assign pipe_out_ready = ready_q;
    assign underflow      = under_q;
    assign overflow       = over_q;
    assign word_count     = count_q;
    assign level          = level_q;
endmodule
